// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style accumulator core: opcodes, FSM states
// and instruction-field widths.
package sap_pkg;

  localparam int OPC_W = 4;
  localparam int STATE_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_JC  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

endpackage

// File: rtl/sap_alu.sv
// Accumulator ALU: add or subtract (two's complement) with carry-out and zero.
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W-1:0] b_eff;

  // For SUB, carry-out of A + ~B + 1 is set when no borrow occurs (A >= B).
  assign b_eff  = sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];
  assign zero   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core.sv
// Multi-cycle accumulator CPU with internal program RAM, a load port and
// an output register; fsm_state exposes the controller state.
module sap_core
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        fsm_state
);

  if (DATA_W < OPC_W + ADDR_W) begin : g_width_check
    $error("sap_core: DATA_W must be at least 4 + ADDR_W");
  end

  state_e              state, state_next;
  logic [ADDR_W-1:0]   mar;
  logic [OPC_W-1:0]    ir_op;
  logic [ADDR_W-1:0]   ir_arg;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   ram_rdata;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_zero;
  logic                prog_ok, sta_wr;

  assign ram_rdata = mem[mar];

  // The load port is only honoured while the core is stopped.
  assign prog_ok   = prog_we && (state == ST_IDLE || state == ST_HALT);
  assign sta_wr    = (state == ST_T4) && (ir_op == OP_STA);
  assign ram_we    = prog_ok || sta_wr;
  assign ram_waddr = sta_wr ? mar : prog_addr;
  assign ram_wdata = sta_wr ? a_reg : prog_data;

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .sub    (ir_op == OP_SUB),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (run) state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        case (ir_op)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_next = ST_T4;
          OP_HLT:                         state_next = ST_HALT;
          default:                        state_next = ST_T1;
        endcase
      end
      ST_T4:   state_next = (ir_op == OP_ADD || ir_op == OP_SUB) ? ST_T5 : ST_T1;
      ST_T5:   state_next = ST_T1;
      ST_HALT: if (!run) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      mar        <= '0;
      ir_op      <= '0;
      ir_arg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_HALT: if (!run) pc <= '0;
        ST_T1:   mar <= pc;
        ST_T2: begin
          ir_op  <= ram_rdata[DATA_W-1 -: OPC_W];
          ir_arg <= ram_rdata[ADDR_W-1:0];
          pc     <= pc + 1'b1;
        end
        ST_T3: begin
          case (ir_op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: mar <= ir_arg;
            OP_LDI: begin
              a_reg     <= {{(DATA_W-ADDR_W){1'b0}}, ir_arg};
              zero_flag <= (ir_arg == '0);
            end
            OP_JMP: pc <= ir_arg;
            OP_JZ:  if (zero_flag) pc <= ir_arg;
            OP_JC:  if (carry_flag) pc <= ir_arg;
            OP_OUT: begin
              out_data  <= a_reg;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_T4: begin
          if (ir_op == OP_LDA) begin
            a_reg     <= ram_rdata;
            zero_flag <= (ram_rdata == '0);
          end else if (ir_op == OP_ADD || ir_op == OP_SUB) begin
            b_reg <= ram_rdata;
          end
        end
        ST_T5: begin
          a_reg      <= alu_result;
          zero_flag  <= alu_zero;
          carry_flag <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  assign acc       = a_reg;
  assign busy      = (state == ST_T1) || (state == ST_T2) || (state == ST_T3) ||
                     (state == ST_T4) || (state == ST_T5);
  assign halted    = (state == ST_HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_sap_core.sv
// Directed-program bench for sap_core: an 8/4 core runs small programs with
// hand-computed results, and a 12/8 core checks PC wrap over an all-NOP RAM.
module tb_sap_core;

  logic       clock;
  logic       reset;
  logic       run;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] pc;
  logic [7:0] acc;
  logic       zero_flag, carry_flag, busy, halted;
  logic [2:0] fsm_state;

  logic        w_run, w_prog_we;
  logic [7:0]  w_prog_addr;
  logic [11:0] w_prog_data;
  logic [11:0] w_out_data, w_acc;
  logic        w_out_valid, w_zero, w_carry, w_busy, w_halted;
  logic [7:0]  w_pc;
  logic [2:0]  w_state;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int w_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] shadow [16];

  sap_core #(.DATA_W(8), .ADDR_W(4)) u_dut (
    .clock(clock), .reset(reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data),
    .out_valid(out_valid), .pc(pc), .acc(acc), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .busy(busy), .halted(halted), .fsm_state(fsm_state)
  );

  sap_core #(.DATA_W(12), .ADDR_W(8)) u_wide (
    .clock(clock), .reset(reset), .run(w_run), .prog_we(w_prog_we),
    .prog_addr(w_prog_addr), .prog_data(w_prog_data), .out_data(w_out_data),
    .out_valid(w_out_valid), .pc(w_pc), .acc(w_acc), .zero_flag(w_zero),
    .carry_flag(w_carry), .busy(w_busy), .halted(w_halted), .fsm_state(w_state)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every out_valid pulse consumes one expected word.
  always @(negedge clock) begin
    if (out_valid) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_data: unexpected pulse got=%0h expected=none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data: got=%0h expected=%0h", out_data, e);
        end
      end
    end
    if (w_out_valid) w_pulses++;
  end

  // Driver tasks: called at a negedge, return at a negedge.
  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clock);
    prog_we = 1'b0;
    shadow[a] = d;
  endtask

  // we_cycle: -1 none, 0 write together with run, n>0 write during busy cycle n.
  task automatic run_to_halt(input int budget, input int we_cycle, input logic [3:0] wa,
                             input logic [7:0] wd, output int busy_cycles);
    bit done;
    busy_cycles = 0;
    done = 0;
    run = 1'b1;
    if (we_cycle == 0) begin
      prog_we = 1'b1; prog_addr = wa; prog_data = wd;
      shadow[wa] = wd;
    end
    for (int i = 1; i <= budget && !done; i++) begin
      @(negedge clock);
      prog_we = 1'b0;
      if (halted) done = 1;
      else begin
        if (busy) busy_cycles++;
        if (i == we_cycle) begin
          prog_we = 1'b1; prog_addr = wa; prog_data = wd;
        end
      end
    end
    prog_we = 1'b0;
    check("halt_reached", {31'b0, done}, 32'd1);
  endtask

  task automatic stop_run();
    run = 1'b0;
    @(negedge clock);
    check("halt_to_idle_pc", {28'b0, pc}, 32'd0);
    check("halt_to_idle_halted", {31'b0, halted}, 32'd0);
  endtask

  initial begin
    int bc, p0, bad, cnt;
    bit wrapped, w_busy_ok;
    logic [7:0] prev_pc;
    reset = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    w_run = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_pc", {28'b0, pc}, 32'd0);
    check("rst_acc", {24'b0, acc}, 32'd0);
    check("rst_out", {23'b0, out_valid, out_data}, 32'd0);
    check("rst_flags", {30'b0, zero_flag, carry_flag}, 32'd0);
    check("rst_busy_halted", {30'b0, busy, halted}, 32'd0);
    check("rst_state", {29'b0, fsm_state}, 32'd0);

    for (int i = 0; i < 16; i++) load(i[3:0], 8'h00);

    // Arithmetic program: 4 + 2 + 8 - 10 = 4
    load(4'h0, 8'h0F); load(4'h1, 8'h1E); load(4'h2, 8'h1D); load(4'h3, 8'h2C);
    load(4'h4, 8'hE0); load(4'h5, 8'hF0);
    load(4'hF, 8'h04); load(4'hE, 8'h02); load(4'hD, 8'h08); load(4'hC, 8'h0A);
    p0 = pulses;
    exp_q.push_back(8'h04);
    run_to_halt(100, -1, 4'h0, 8'h00, bc);
    check("p1_busy_cycles", bc, 32'd25);
    check("p1_pulses", pulses - p0, 32'd1);
    check("p1_acc", {24'b0, acc}, 32'h04);
    check("p1_flags", {30'b0, zero_flag, carry_flag}, 32'b01);
    stop_run();
    check("p1_acc_after_idle", {24'b0, acc}, 32'h04);

    // Countdown loop; word 0 written in the same cycle run is raised
    load(4'h1, 8'h2F); load(4'h2, 8'h64); load(4'h3, 8'h51);
    load(4'h4, 8'hE0); load(4'h5, 8'hF0); load(4'hF, 8'h01);
    p0 = pulses;
    exp_q.push_back(8'h00);
    run_to_halt(200, 0, 4'h0, 8'h43, bc);
    check("p2_busy_cycles", bc, 32'd39);
    check("p2_pulses", pulses - p0, 32'd1);
    check("p2_flags", {30'b0, zero_flag, carry_flag}, 32'b11);
    stop_run();

    // Overflow then store
    load(4'h0, 8'h0F); load(4'h1, 8'h1E); load(4'h2, 8'h39); load(4'h3, 8'hF0);
    load(4'hF, 8'hFF); load(4'hE, 8'h01); load(4'h9, 8'h55);
    p0 = pulses;
    run_to_halt(100, -1, 4'h0, 8'h00, bc);
    shadow[9] = 8'h00;
    check("p3_busy_cycles", bc, 32'd16);
    check("p3_acc", {24'b0, acc}, 32'h00);
    check("p3_flags", {30'b0, zero_flag, carry_flag}, 32'b11);
    check("p3_ram9", {24'b0, u_dut.mem[9]}, 32'h00);
    check("p3_pulses", pulses - p0, 32'd0);
    stop_run();

    // Reset during T4 of ADD
    load(4'h0, 8'h0F); load(4'h1, 8'hE0); load(4'h2, 8'h1E); load(4'h3, 8'hE0);
    load(4'h4, 8'hF0); load(4'hF, 8'h03); load(4'hE, 8'h05);
    exp_q.push_back(8'h03);
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 11; i++) begin
      @(negedge clock);
      if (busy) cnt++;
    end
    check("p4_reached_add_t4", {29'b0, fsm_state}, 32'd4);
    check("p4_acc_before_reset", {24'b0, acc}, 32'h03);
    reset = 1'b1;
    #1;
    check("p4_rst_pc", {28'b0, pc}, 32'd0);
    check("p4_rst_acc", {24'b0, acc}, 32'd0);
    check("p4_rst_out", {23'b0, out_valid, out_data}, 32'd0);
    check("p4_rst_flags_busy", {28'b0, zero_flag, carry_flag, busy, halted}, 32'd0);
    check("p4_rst_state", {29'b0, fsm_state}, 32'd0);
    @(negedge clock);
    run = 1'b0;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) if (u_dut.mem[i] !== shadow[i]) bad++;
    check("p4_ram_unchanged", bad, 32'd0);
    @(negedge clock);
    p0 = pulses;
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h08);
    run_to_halt(100, -1, 4'h0, 8'h00, bc);
    check("p4_rerun_busy", bc, 32'd18);
    check("p4_rerun_pulses", pulses - p0, 32'd2);
    check("p4_rerun_out", {24'b0, out_data}, 32'h08);

    // Load port is ignored while busy, honoured in HALT
    stop_run();
    load(4'h0, 8'h41); load(4'h1, 8'h42); load(4'h2, 8'hF0);
    run_to_halt(100, 2, 4'h5, 8'hA7, bc);
    check("p5_busy_cycles", bc, 32'd9);
    check("p5_ram5_busy_write", {24'b0, u_dut.mem[5]}, {24'b0, shadow[5]});
    load(4'h5, 8'hA7);
    check("p5_ram5_halt_write", {24'b0, u_dut.mem[5]}, 32'hA7);
    check("p5_acc", {24'b0, acc}, 32'h02);
    stop_run();

    // Wide core: all-NOP RAM, PC must wrap 0xFF -> 0x00
    for (int i = 0; i < 256; i++) begin
      w_prog_we = 1'b1; w_prog_addr = i[7:0]; w_prog_data = 12'h800;
      @(negedge clock);
    end
    w_prog_we = 1'b0;
    w_run = 1'b1;
    wrapped = 0;
    w_busy_ok = 1;
    prev_pc = w_pc;
    for (int i = 0; i < 1000 && !wrapped; i++) begin
      @(negedge clock);
      if (!w_busy) w_busy_ok = 0;
      if (prev_pc == 8'hFF && w_pc == 8'h00) wrapped = 1;
      prev_pc = w_pc;
    end
    repeat (6) begin
      @(negedge clock);
      if (!w_busy) w_busy_ok = 0;
    end
    check("wide_pc_wrap", {31'b0, wrapped}, 32'd1);
    check("wide_busy_held", {31'b0, w_busy_ok}, 32'd1);
    check("wide_no_out_valid", w_pulses, 32'd0);
    check("wide_not_halted", {31'b0, w_halted}, 32'd0);
    w_run = 1'b0;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
